// File: rtl/s_m_ctrl.sv
// s_m_ctrl: valid/ready front-end and result capture for the s_m multiplier.
// Starts s_m via its rst pin, waits the fixed latency, then registers P.
module s_m_ctrl #(
  parameter int WIDTH      = 4,
  parameter int MUL_CYCLES = 5,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               mul_rst,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_p,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [WIDTH-1:0]   out_a,
  output logic [WIDTH-1:0]   out_b,
  output logic [CNT_W-1:0]   done_cnt
);

  localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    HOLD
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       accept;
  logic       capture;
  logic       handshake;
  logic       slot_free;

  assign handshake = out_valid & out_ready;
  assign slot_free = ~out_valid | out_ready;
  assign accept    = in_ready & in_valid;

  // s_m is held cleared during reset and pulsed for one START cycle.
  assign mul_rst = rst | (state == START);

  // Next-state, wait count and capture decision.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    in_ready  = 1'b0;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = START;
      end
      START: begin
        state_nxt = WAIT;
        cnt_nxt   = CNT_INIT;
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          if (slot_free) begin
            capture   = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = HOLD;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      HOLD: begin
        if (slot_free) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and latency counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Operands stay put from START until the next acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a <= '0;
      mul_b <= '0;
    end else if (accept) begin
      mul_a <= in_a;
      mul_b <= in_b;
    end
  end

  // Result slot: a capture on a handshake edge keeps valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_p     <= '0;
      out_a     <= '0;
      out_b     <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_p     <= mul_p;
      out_a     <= mul_a;
      out_b     <= mul_b;
    end else if (handshake) begin
      out_valid <= 1'b0;
    end
  end

  // Delivered-product counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_cnt <= '0;
    end else if (handshake) begin
      done_cnt <= done_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: doc/s_m_ctrl.md
Name: s_m_ctrl

Overview:
- Handshake front-end and result capture stage that wraps the s_m sequential 4x4 multiplier.
- Accepts operand pairs on a valid/ready input channel and drives s_m's a, b and rst (rst doubles as s_m's start pulse).
- Waits the fixed multiplier latency, then captures P into an output register with a valid/ready result channel.
- Counts completed products.

Parameters:
- WIDTH, 4: operand width; product is 2*WIDTH.
- MUL_CYCLES, 5: cycles s_m needs after its rst deasserts before P is final. Legal range 1..15.
- CNT_W, 16: width of the completed-product counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- in_a  in  WIDTH  operand a.
- in_b  in  WIDTH  operand b.
- mul_rst  out  1  to s_m rst; high = clear/start.
- mul_a  out  WIDTH  to s_m a.
- mul_b  out  WIDTH  to s_m b.
- mul_p  in  2*WIDTH  from s_m P.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_p  out  2*WIDTH  captured product.
- out_a  out  WIDTH  operand a belonging to out_p.
- out_b  out  WIDTH  operand b belonging to out_p.
- done_cnt  out  CNT_W  number of products delivered, i.e. out handshakes.

Behaviour:
- Reset, asynchronous, all values held while rst=1:
  - state=IDLE; mul_rst=1; mul_a=mul_b=0.
  - out_valid=0; out_p=out_a=out_b=0; done_cnt=0; wait counter=0.
  - Reset mid-operation discards any in-flight product; no partial result ever appears on out_*.
- FSM states:
  - IDLE:
    - in_ready=1; mul_rst=0.
    - On in_valid&in_ready: mul_a<=in_a, mul_b<=in_b, go to START.
  - START:
    - in_ready=0; mul_rst=1 for exactly one cycle.
    - Next edge: go to WAIT, cnt<=MUL_CYCLES-1.
  - WAIT:
    - in_ready=0; mul_rst=0; cnt decrements each edge.
    - When cnt==0 and the output slot is free (out_valid==0, or out_valid&out_ready this cycle): out_p<=mul_p, out_a<=mul_a, out_b<=mul_b, out_valid<=1, go to IDLE.
    - When cnt==0 and the slot is occupied: go to HOLD.
  - HOLD:
    - in_ready=0; mul_rst=0.
    - Capture exactly as in WAIT once the slot frees, then go to IDLE.
    - s_m holds P stable until its next rst, so a late capture is valid.
- mul_a/mul_b are stable from the START cycle until the next acceptance.
- Latency: acceptance at edge E0 gives out_valid=1 after edge E0+1+MUL_CYCLES (6 cycles at default) when the slot is free.
- Throughput: one product per MUL_CYCLES+2 cycles (IDLE, START, WAIT x MUL_CYCLES).
- Output channel:
  - out_valid stays high and out_p/out_a/out_b stay stable until out_ready=1.
  - out_valid&out_ready: out_valid<=0 unless a capture happens on the same edge, in which case out_valid stays 1 with the new data.
  - done_cnt increments on each out handshake and wraps from 2^CNT_W-1 to 0.
- Simultaneous events: in IDLE with out_valid=1, a new operand pair is still accepted. The output register is independent; only capture waits for a free slot.
- Arithmetic: no arithmetic in this block. out_p is mul_p verbatim, full 2*WIDTH bits. 15x15=225 must pass unchanged.
- in_valid held low leaves the block in IDLE indefinitely with mul_rst=0.

Test Plan:
- Reset: rst=1 asynchronously mid-WAIT → immediately mul_rst=1, out_valid=0, done_cnt=0. After release, state is IDLE and in_ready=1 within 1 cycle.
- Single product: in_a=3, in_b=5, out_ready=1 → mul_rst high for exactly 1 cycle; out_valid after 6 edges; out_p=15, out_a=3, out_b=5; done_cnt=1.
- Boundary: 15x15 → out_p=225. 0x9 → out_p=0. 15x0 → out_p=0.
- Back-pressure: out_ready=0, issue 2x7 then 4x4 → first result 14 held stable. Second operation enters HOLD; in_ready=0 throughout. Raise out_ready for 1 cycle → 14 consumed and 16 captured on the same edge; out_valid stays 1.
- Exhaustive sweep: all 256 (a,b) pairs back-to-back, out_ready=1 → every out_p equals a*b with matching out_a/out_b. Issue period is 7 cycles; done_cnt=256.
- Counter wrap: CNT_W=4, 17 products → done_cnt=1.
